// File: rtl/bank_command_scheduler.sv
// Single-bank DRAM command scheduler: one held request, open-page policy,
// tRCD/tRP/tRAS/tRFC spacing and a free-running tREFI refresh timer.
module bank_command_scheduler #(
    parameter int unsigned RANK      = 0,
    parameter int unsigned BANKGROUP = 0,
    parameter int unsigned BANK      = 0,
    parameter int unsigned COL_BITS  = 10,
    parameter int unsigned T_RCD     = 3,
    parameter int unsigned T_RP      = 3,
    parameter int unsigned T_RAS     = 6,
    parameter int unsigned T_RFC     = 8,
    parameter int unsigned T_REFI    = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_is_write,
    input  logic [31:0] req_id,
    output logic        cmd_valid,
    output logic        cs,
    output logic        ras,
    output logic        cas,
    output logic        we,
    output logic [31:0] cmd_addr,
    output logic [31:0] cmd_data,
    output logic [31:0] cmd_id,
    output logic        done_valid,
    output logic [31:0] done_id,
    output logic        refresh_overrun
);
    typedef enum logic [2:0] {
        ST_CLOSED, ST_ACTIVATING, ST_OPEN, ST_PRECHARGING, ST_REFRESHING
    } state_t;

    typedef enum logic [3:0] {
        CMD_REFRESH   = 4'b0001,
        CMD_PRECHARGE = 4'b0010,
        CMD_ACTIVATE  = 4'b0011,
        CMD_WRITE     = 4'b0100,
        CMD_READ      = 4'b0101,
        CMD_NOP       = 4'b1111
    } cmd_t;

    state_t                r_state, w_next_state;
    logic                  r_ent_valid, r_ent_write;
    logic [31:0]           r_ent_addr, r_ent_wdata, r_ent_id;
    logic [31-COL_BITS:0]  r_open_row;
    logic [31:0]           r_act_cnt, r_wait_cnt, r_refi_cnt;
    logic                  r_ref_pend, r_ref_ovr;
    logic                  r_cmd_valid, r_done_valid;
    cmd_t                  r_cmd, w_cmd;
    logic [31:0]           r_cmd_addr, r_cmd_data, r_cmd_id, r_done_id;

    logic w_is_act, w_is_pre, w_is_ref, w_is_col;
    logic w_cmd_valid, w_req_cmd, w_row_hit, w_closed_ok, w_fire, w_tick;
    logic w_unused;

    assign w_unused    = ^{RANK, BANKGROUP, BANK};
    assign req_ready   = ~r_ent_valid & ~reset;
    assign w_fire      = req_valid & req_ready;
    assign w_row_hit   = r_ent_addr[31:COL_BITS] == r_open_row;
    assign w_tick      = r_refi_cnt == T_REFI - 1;
    assign w_cmd_valid = w_is_act | w_is_pre | w_is_ref | w_is_col;
    // Precharge on behalf of a pending refresh is not attributed to the request.
    assign w_req_cmd   = w_is_act | w_is_col | (w_is_pre & ~r_ref_pend);

    // Wait states fall through into CLOSED decisions on the edge their timer
    // expires, so each spacing constraint is met with no idle cycle.
    assign w_closed_ok = (r_state == ST_CLOSED)
                       | ((r_state == ST_PRECHARGING) & (r_wait_cnt >= T_RP))
                       | ((r_state == ST_REFRESHING) & (r_wait_cnt >= T_RFC));

    always_comb begin
        w_next_state = r_state;
        w_cmd        = CMD_NOP;
        w_is_act     = 1'b0;
        w_is_pre     = 1'b0;
        w_is_ref     = 1'b0;
        w_is_col     = 1'b0;
        case (r_state)
            ST_ACTIVATING, ST_OPEN: begin
                if (r_state == ST_ACTIVATING && r_act_cnt >= T_RCD)
                    w_next_state = ST_OPEN;
                if (r_ref_pend || (r_ent_valid && !w_row_hit)) begin
                    if (r_act_cnt >= T_RAS) begin
                        w_is_pre     = 1'b1;
                        w_cmd        = CMD_PRECHARGE;
                        w_next_state = ST_PRECHARGING;
                    end
                end else if (r_ent_valid && r_act_cnt >= T_RCD) begin
                    w_is_col     = 1'b1;
                    w_cmd        = r_ent_write ? CMD_WRITE : CMD_READ;
                    w_next_state = ST_OPEN;
                end
            end
            default: begin
                if (w_closed_ok) begin
                    w_next_state = ST_CLOSED;
                    if (r_ref_pend) begin
                        w_is_ref     = 1'b1;
                        w_cmd        = CMD_REFRESH;
                        w_next_state = ST_REFRESHING;
                    end else if (r_ent_valid) begin
                        w_is_act     = 1'b1;
                        w_cmd        = CMD_ACTIVATE;
                        w_next_state = ST_ACTIVATING;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_CLOSED;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ent_valid <= 1'b0;
            r_ent_write <= 1'b0;
            r_ent_addr  <= '0;
            r_ent_wdata <= '0;
            r_ent_id    <= '0;
            r_open_row  <= '0;
            r_act_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_refi_cnt  <= '0;
            r_ref_pend  <= 1'b0;
            r_ref_ovr   <= 1'b0;
        end else begin
            if (w_is_col) begin
                r_ent_valid <= 1'b0;
            end else if (w_fire) begin
                r_ent_valid <= 1'b1;
                r_ent_write <= req_is_write;
                r_ent_addr  <= req_addr;
                r_ent_wdata <= req_wdata;
                r_ent_id    <= req_id;
            end
            if (w_is_act)
                r_open_row <= r_ent_addr[31:COL_BITS];
            if (w_is_act)              r_act_cnt <= 32'd1;
            else if (r_act_cnt != '1)  r_act_cnt <= r_act_cnt + 32'd1;
            if (w_is_pre || w_is_ref)  r_wait_cnt <= 32'd1;
            else if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + 32'd1;
            r_refi_cnt <= w_tick ? '0 : r_refi_cnt + 32'd1;
            r_ref_pend <= (r_ref_pend & ~w_is_ref) | w_tick;
            r_ref_ovr  <= r_ref_ovr | (w_tick & r_ref_pend);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_valid  <= 1'b0;
            r_cmd        <= CMD_NOP;
            r_cmd_addr   <= '0;
            r_cmd_data   <= '0;
            r_cmd_id     <= '0;
            r_done_valid <= 1'b0;
            r_done_id    <= '0;
        end else begin
            r_cmd_valid  <= w_cmd_valid;
            r_cmd        <= w_cmd;
            r_cmd_addr   <= w_req_cmd ? r_ent_addr : '0;
            r_cmd_data   <= (w_is_col && r_ent_write) ? r_ent_wdata : '0;
            r_cmd_id     <= w_req_cmd ? r_ent_id : '0;
            r_done_valid <= w_is_col;
            r_done_id    <= w_is_col ? r_ent_id : '0;
        end
    end

    assign cmd_valid         = r_cmd_valid;
    assign {cs, ras, cas, we} = r_cmd;
    assign cmd_addr          = r_cmd_addr;
    assign cmd_data          = r_cmd_data;
    assign cmd_id            = r_cmd_id;
    assign done_valid        = r_done_valid;
    assign done_id           = r_done_id;
    assign refresh_overrun   = r_ref_ovr;
endmodule

// File: tb/tb_bank_command_scheduler.sv
// Bench for bank_command_scheduler: timestamp-based reference model checked every
// cycle, directed literal expectations, random traffic, and an overrun instance.
module tb_bank_command_scheduler;
    localparam int COLB   = 10;
    localparam int T_RCD  = 3;
    localparam int T_RP   = 3;
    localparam int T_RAS  = 6;
    localparam int T_RFC  = 8;
    localparam int T_REFI = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_is_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, req_id = '0;
    logic        req_ready, cmd_valid, cs, ras, cas, we, done_valid, refresh_overrun;
    logic [31:0] cmd_addr, cmd_data, cmd_id, done_id;

    logic        reset2 = 1'b1, req_valid2 = 1'b0;
    logic [31:0] req_addr2 = '0, req_id2 = '0;
    logic        req_ready2, cmd_valid2, cs2, ras2, cas2, we2, done_valid2, ovr2;
    logic [31:0] cmd_addr2, cmd_data2, cmd_id2, done_id2;

    int n_chk = 0, n_pass = 0;
    logic chk_on = 1'b0;
    logic [4:0] w_cmdv;
    assign w_cmdv = {cmd_valid, cs, ras, cas, we};

    always #5 clk = ~clk;

    bank_command_scheduler #(
        .RANK(0), .BANKGROUP(0), .BANK(0), .COL_BITS(COLB), .T_RCD(T_RCD),
        .T_RP(T_RP), .T_RAS(T_RAS), .T_RFC(T_RFC), .T_REFI(T_REFI)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_is_write(req_is_write),
        .req_id(req_id), .cmd_valid(cmd_valid), .cs(cs), .ras(ras), .cas(cas), .we(we),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_id(cmd_id),
        .done_valid(done_valid), .done_id(done_id), .refresh_overrun(refresh_overrun)
    );

    // tRAS longer than tREFI so a second refresh tick lands while the first is pending.
    bank_command_scheduler #(
        .RANK(0), .BANKGROUP(0), .BANK(1), .COL_BITS(COLB), .T_RCD(2),
        .T_RP(2), .T_RAS(50), .T_RFC(4), .T_REFI(20)
    ) dut_ovr (
        .clk(clk), .reset(reset2), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_addr(req_addr2), .req_wdata(32'h0), .req_is_write(1'b0),
        .req_id(req_id2), .cmd_valid(cmd_valid2), .cs(cs2), .ras(ras2), .cas(cas2), .we(we2),
        .cmd_addr(cmd_addr2), .cmd_data(cmd_data2), .cmd_id(cmd_id2),
        .done_valid(done_valid2), .done_id(done_id2), .refresh_overrun(ovr2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Reference model: remembers when the last ACT/PRE/REF happened and checks
    // elapsed cycles against each timing rule.
    longint      cyc = 0, m_r0 = 0;
    longint      m_t_act = -1000000, m_t_pre = -1000000, m_t_ref = -1000000;
    logic        m_ent = 1'b0, m_wr = 1'b0, m_open = 1'b0, m_pend = 1'b0, m_ovr = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_id = '0, m_row = '0;
    logic        e_cmd_valid = 1'b0, e_done_v = 1'b0;
    logic [3:0]  e_cmd = 4'hF;
    logic [31:0] e_addr = '0, e_data = '0, e_id = '0, e_done_id = '0;

    always @(posedge clk) begin
        logic ref_now, fire, tick;
        cyc++;
        ref_now = 1'b0;
        e_cmd_valid = 1'b0; e_cmd = 4'hF; e_addr = '0; e_data = '0; e_id = '0;
        e_done_v = 1'b0; e_done_id = '0;
        if (reset) begin
            m_ent = 1'b0; m_open = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
            m_t_act = -1000000; m_t_pre = -1000000; m_t_ref = -1000000;
            m_r0 = cyc;
        end else begin
            fire = req_valid && !m_ent;
            if (m_open) begin
                if (m_pend || (m_ent && (m_addr >> COLB) != m_row)) begin
                    if (cyc - m_t_act >= T_RAS) begin
                        e_cmd_valid = 1'b1; e_cmd = 4'b0010;
                        if (!m_pend) begin e_addr = m_addr; e_id = m_id; end
                        m_open = 1'b0; m_t_pre = cyc;
                    end
                end else if (m_ent && cyc - m_t_act >= T_RCD) begin
                    e_cmd_valid = 1'b1; e_cmd = m_wr ? 4'b0100 : 4'b0101;
                    e_addr = m_addr; e_data = m_wr ? m_wdata : '0; e_id = m_id;
                    e_done_v = 1'b1; e_done_id = m_id; m_ent = 1'b0;
                end
            end else if (cyc - m_t_pre >= T_RP && cyc - m_t_ref >= T_RFC) begin
                if (m_pend) begin
                    e_cmd_valid = 1'b1; e_cmd = 4'b0001; m_t_ref = cyc; ref_now = 1'b1;
                end else if (m_ent) begin
                    e_cmd_valid = 1'b1; e_cmd = 4'b0011; e_addr = m_addr; e_id = m_id;
                    m_open = 1'b1; m_row = m_addr >> COLB; m_t_act = cyc;
                end
            end
            tick = ((cyc - m_r0) % T_REFI) == 0;
            if (tick && m_pend) m_ovr = 1'b1;
            m_pend = (m_pend && !ref_now) || tick;
            if (fire) begin
                m_ent = 1'b1; m_wr = req_is_write; m_addr = req_addr;
                m_wdata = req_wdata; m_id = req_id;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmd", 64'(w_cmdv), 64'({e_cmd_valid, e_cmd}));
            chk("cmd_addr", 64'(cmd_addr), 64'(e_addr));
            chk("cmd_data", 64'(cmd_data), 64'(e_data));
            chk("cmd_id", 64'(cmd_id), 64'(e_id));
            chk("done", 64'({done_valid, done_id}), 64'({e_done_v, e_done_id}));
            chk("req_ready", 64'(req_ready), 64'(!m_ent && !reset));
            chk("overrun", 64'(refresh_overrun), 64'(m_ovr));
        end
    end

    task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [31:0] id);
        req_valid = 1'b1; req_addr = a; req_is_write = w; req_wdata = d; req_id = id;
    endtask

    // Overrun instance: tick at +20 sets pending, tick at +40 overruns.
    initial begin
        repeat (4) @(negedge clk);
        #1 reset2 = 1'b0;
        @(negedge clk);
        chk("ovr_ready_after_rst", 64'(req_ready2), 64'(1));
        #1 req_valid2 = 1'b1; req_addr2 = 32'h100; req_id2 = 32'd5;
        @(negedge clk);
        #1 req_valid2 = 1'b0;
        repeat (8) @(negedge clk);
        chk("ovr_early", 64'(ovr2), 64'(0));
        repeat (40) @(negedge clk);
        chk("ovr_set", 64'(ovr2), 64'(1));
        repeat (100) @(negedge clk);
        chk("ovr_sticky", 64'(ovr2), 64'(1));
        #1 reset2 = 1'b1;
        #1 chk("ovr_ready_in_rst", 64'(req_ready2), 64'(0));
        @(negedge clk);
        chk("ovr_cleared", 64'(ovr2), 64'(0));
        #1 reset2 = 1'b0;
    end

    initial begin
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_cmd", 64'(w_cmdv), 64'(5'b01111));
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'(1));
        #1 send(32'h1400, 1'b0, 32'h0, 32'd7);
        @(negedge clk);
        chk("accept_no_cmd", 64'(w_cmdv), 64'(5'b01111));
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("act", 64'({w_cmdv, cmd_addr, cmd_id[7:0]}), 64'({5'b10011, 32'h1400, 8'd7}));
        repeat (3) @(negedge clk);
        chk("read", 64'(w_cmdv), 64'(5'b10101));
        chk("read_done", 64'({done_valid, done_id}), 64'({1'b1, 32'd7}));
        chk("ready_after_col", 64'(req_ready), 64'(1));
        #1 send(32'h1404, 1'b1, 32'hDEADBEEF, 32'd8);
        @(negedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("hit_write", 64'(w_cmdv), 64'(5'b10100));
        chk("hit_wdata", 64'(cmd_data), 64'(32'hDEADBEEF));
        chk("hit_done", 64'({done_valid, done_id}), 64'({1'b1, 32'd8}));
        #1 send(32'h8000, 1'b0, 32'h0, 32'd9);
        @(negedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("miss_pre", 64'({w_cmdv, cmd_addr}), 64'({5'b10010, 32'h8000}));
        repeat (3) @(negedge clk);
        chk("miss_act", 64'({w_cmdv, cmd_addr, cmd_id[7:0]}), 64'({5'b10011, 32'h8000, 8'd9}));
        repeat (3) @(negedge clk);
        chk("miss_read", 64'({w_cmdv, cmd_id}), 64'({5'b10101, 32'd9}));

        while (cyc < m_r0 + 101) @(negedge clk);
        chk("ref_pre", 64'({w_cmdv, cmd_addr, cmd_id[7:0]}), 64'({5'b10010, 32'h0, 8'h0}));
        #1 send(32'h8004, 1'b0, 32'h0, 32'd10);
        @(negedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("ref_trp_gap", 64'(w_cmdv), 64'(5'b01111));
        @(negedge clk);
        chk("refresh", 64'({w_cmdv, cmd_addr, cmd_id}), 64'({5'b10001, 32'h0, 32'h0}));
        repeat (7) @(negedge clk);
        chk("ref_trfc_gap", 64'(w_cmdv), 64'(5'b01111));
        @(negedge clk);
        chk("post_ref_act", 64'({w_cmdv, cmd_id}), 64'({5'b10011, 32'd10}));
        repeat (3) @(negedge clk);
        chk("post_ref_read", 64'({done_valid, done_id}), 64'({1'b1, 32'd10}));

        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1 send(32'h2000, 1'b0, 32'h0, 32'd11);
        @(negedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("act_before_rst", 64'({w_cmdv, cmd_id}), 64'({5'b10011, 32'd11}));
        #1 reset = 1'b1;
        #1 chk("ready_in_rst", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("rst_nop", 64'({w_cmdv, cmd_addr, cmd_id}), 64'({5'b01111, 32'h0, 32'h0}));
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_back", 64'(req_ready), 64'(1));
        #1 send(32'h2000, 1'b0, 32'h0, 32'd12);
        @(negedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("restart_act", 64'({w_cmdv, cmd_id}), 64'({5'b10011, 32'd12}));

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            reset        = ($urandom_range(0, 299) == 0);
            req_valid    = $urandom_range(0, 1) == 1;
            req_addr     = (32'($urandom_range(0, 3)) << COLB) | 32'($urandom_range(0, 1023));
            req_is_write = $urandom_range(0, 1) == 1;
            req_wdata    = $urandom;
            req_id       = $urandom;
        end
        @(negedge clk);
        #1 reset = 1'b0; req_valid = 1'b0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
